// File: rtl/aes_v2_mix_sequencer.sv
// Runs a 128-bit AES state through NUM_LANES single-cycle column-mix units, NUM_LANES columns per cycle.
// Optional abort path enabled by defining AES_MIX_SEQ_FLUSH_EN (adds input port flush).

module aes_v2_mix_col (
  input  logic        valid_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic        enc_i,
  output logic        ready_o,
  output logic [31:0] result_o
);

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(input logic [7:0] a0, input logic [7:0] a1,
                                      input logic [7:0] a2, input logic [7:0] a3);
    return {xt(a3 ^ a0) ^ a0 ^ a1 ^ a2,
            xt(a2 ^ a3) ^ a3 ^ a0 ^ a1,
            xt(a1 ^ a2) ^ a2 ^ a3 ^ a0,
            xt(a0 ^ a1) ^ a1 ^ a2 ^ a3};
  endfunction

  logic [7:0]  b0, b1, b2, b3, u, v;
  logic [31:0] pad_unused;

  assign pad_unused = {rs1_i[31:16], rs2_i[15:0]};
  assign ready_o    = valid_i;

  // InvMixColumns = MixColumns after a {04}-multiply preconditioning step on opposite byte pairs.
  always_comb begin
    b0 = rs1_i[7:0];
    b1 = rs1_i[15:8];
    b2 = rs2_i[23:16];
    b3 = rs2_i[31:24];
    u  = xt(xt(b0 ^ b2));
    v  = xt(xt(b1 ^ b3));
    if (!enc_i) begin
      b0 = b0 ^ u;
      b1 = b1 ^ v;
      b2 = b2 ^ u;
      b3 = b3 ^ v;
    end
    result_o = valid_i ? mix(b0, b1, b2, b3) : 32'h0;
  end

endmodule

module aes_v2_mix_sequencer #(
  parameter int NUM_LANES = 1
) (
  input  logic         g_clk,
  input  logic         g_reset,
`ifdef AES_MIX_SEQ_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_enc,
  input  logic [127:0] req_state,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state,
  output logic         busy
);

  if (NUM_LANES != 1 && NUM_LANES != 2 && NUM_LANES != 4) begin : g_bad_lanes
    $error("aes_v2_mix_sequencer: NUM_LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [1:0] STEP = 2'(NUM_LANES);
  localparam logic [1:0] LAST = 2'(4 - NUM_LANES);

  state_t         state_q;
  logic [1:0]     col_q;
  logic [127:0]   buf_q;
  logic           enc_q;
  logic [127:0]   res_q, res_d;
  logic           rsp_valid_q;
  logic           busy_q;
  logic           flush_w;
  logic           accept;
  logic           lane_vld;
  logic [31:0]    lane_res [NUM_LANES];
  logic [NUM_LANES-1:0] lane_rdy_unused;

`ifdef AES_MIX_SEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign req_ready = ((state_q == S_IDLE) | ((state_q == S_DONE) & rsp_ready)) & ~flush_w;
  assign accept    = req_valid & req_ready;
  assign lane_vld  = (state_q == S_BUSY);
  assign rsp_valid = rsp_valid_q;
  assign rsp_state = res_q;
  assign busy      = busy_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [1:0]  idx;
    logic [31:0] w;
    assign idx = col_q + 2'(l);
    assign w   = buf_q[{idx, 5'b0} +: 32];
    aes_v2_mix_col u_mix (
      .valid_i  (lane_vld),
      .rs1_i    ({16'h0, w[15:0]}),
      .rs2_i    ({w[31:16], 16'h0}),
      .enc_i    (enc_q),
      .ready_o  (lane_rdy_unused[l]),
      .result_o (lane_res[l])
    );
  end

  always_comb begin
    res_d = res_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      res_d[{col_q + 2'(l), 5'b0} +: 32] = lane_res[l];
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= S_IDLE;
      col_q       <= 2'd0;
      buf_q       <= 128'h0;
      enc_q       <= 1'b0;
      res_q       <= 128'h0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush_w) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            buf_q   <= req_state;
            enc_q   <= req_enc;
            col_q   <= 2'd0;
            state_q <= S_BUSY;
            busy_q  <= 1'b1;
          end
        end
        S_BUSY: begin
          res_q <= res_d;
          col_q <= col_q + STEP;
          if (col_q == LAST) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          // Handshake and a new accept may coincide: go straight back to BUSY.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (accept) begin
              buf_q   <= req_state;
              enc_q   <= req_enc;
              col_q   <= 2'd0;
              state_q <= S_BUSY;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_v2_mix_sequencer.md
Name: aes_v2_mix_sequencer

Overview:
Sequences a full 128-bit AES state through the 32-bit lightweight MixColumns/InvMixColumns datapath, one or more columns per cycle. Instantiates NUM_LANES copies of the existing column-mix unit and time-multiplexes the four state columns across them. It accepts requests and returns results over valid/ready handshakes, so it can sit between an AES round sequencer and the shared mix datapath.

Parameters:
NUM_LANES, 1, number of column-mix instances; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
g_clk      input   1    clock; all state updates on the rising edge
g_reset    input   1    reset; asynchronous, active-high
req_valid  input   1    request present
req_ready  output  1    sequencer can accept a request
req_enc    input   1    1 = MixColumns, 0 = InvMixColumns
req_state  input   128  input state; column c = bits [32c+31:32c], byte 0 of a column = its low byte
rsp_valid  output  1    result available
rsp_ready  input   1    consumer accepts result
rsp_state  output  128  result state, same column/byte layout
busy       output  1    high in BUSY

Behaviour:
- FSM states: IDLE, BUSY, DONE. Column counter col is 2 bits wide and advances by NUM_LANES.
- Reset (async assert): state=IDLE, col=0, rsp_valid=0, rsp_state=0, busy=0, internal state/enc buffers=0. req_ready reads 1 while in IDLE.
- req_ready = (IDLE) | (DONE & rsp_ready). A request is accepted when req_valid & req_ready.
- On accept: latch req_state and req_enc into internal buffers, set col=0, go to BUSY. After acceptance, req_* inputs are don't-care.
- BUSY, each cycle: lane L processes buffer column col+L and writes the result to column col+L of the result register. col advances by NUM_LANES. The column that completes col=3 moves the FSM to DONE.
- Lane feed for column w: rs1 = {16'h0, w[15:0]}, rs2 = {w[31:16], 16'h0}, enc = latched enc, valid = 1 in BUSY. The lane ready output is ignored because the unit is single-cycle.
- Latency: accept edge to rsp_valid high is 4/NUM_LANES + 1 cycles (5 / 3 / 2 cycles).
- DONE: rsp_valid=1 and rsp_state is stable until rsp_valid & rsp_ready.
  - Handshake with no new request: go to IDLE, rsp_valid=0 next cycle; rsp_state keeps its value.
  - Handshake and accept in the same cycle: go directly to BUSY with the new request. Back-to-back throughput is one result per 4/NUM_LANES + 1 cycles.
- A request arriving while in BUSY is not accepted; req_valid must be held (requester obligation).
- The result register is fully overwritten before each rsp_valid, so no stale columns reach the output.
- Reset asserted mid-operation: immediately IDLE, in-flight result discarded, rsp_valid=0.

Optional Feature:
AES_MIX_SEQ_FLUSH_EN:
- Defined: adds input port flush (1 bit).
  - flush=1 in any state: FSM goes to IDLE and rsp_valid=0 next cycle; any in-flight or unconsumed result is dropped.
  - req_ready is forced to 0 in a cycle where flush=1.
  - flush has priority over accept and over the response handshake.
- Undefined: the port is absent and there is no abort path; an operation always runs to DONE.

Test Plan:
1. NUM_LANES=1, enc=1, req_state={32'h4c31262d,32'hd5d4d4d4,32'h5c220af2,32'h455313db} -> rsp_state={32'hf8bd7e4d,32'hd6d7d5d5,32'h9d58dc9f,32'hbca14d8e}; rsp_valid rises exactly 5 cycles after accept; busy high 4 cycles.
2. enc=0 with the test-1 output as input -> returns the test-1 input; repeat for NUM_LANES=2 and 4 with latency 3 and 2 cycles respectively.
3. Invariant columns: req_state all bytes 8'h01, then all bytes 8'hc6, enc=1 and enc=0 -> output equals input in all four cases.
4. Backpressure and back-to-back:
   - Hold rsp_ready=0 for 10 cycles in DONE -> rsp_state stable, req_ready=0.
   - Then assert rsp_ready together with a new req_valid -> new request accepted in the handshake cycle, busy next cycle.
5. Assert g_reset asynchronously during BUSY col=2 -> rsp_valid=0, req_ready=1 immediately. A following request completes with correct data.
6. Flush (AES_MIX_SEQ_FLUSH_EN defined):
   - flush during BUSY -> no rsp_valid for that request.
   - flush in DONE with rsp_ready=1 and req_valid=1 -> nothing accepted, FSM in IDLE next cycle.
